timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter START_TENS, default 4'd3, BCD tens digit loaded at reset and on clear.
REQ-002 Parameter START_ONES, default 4'd0, BCD ones digit loaded at reset and on clear.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  one-cycle count-enable pulse (1 Hz), synchronous to clk.
REQ-006 btn_pause  input  1  debounced pause/resume button level, 1 = pressed.
REQ-007 btn_clear  input  1  debounced clear button level, 1 = pressed.
REQ-008 bcd_tens  output  4  current tens digit, BCD 0-9.
REQ-009 bcd_ones  output  4  current ones digit, BCD 0-9.
REQ-010 counting  output  1  high exactly while the state is COUNT.
REQ-011 done  output  1  high exactly while the state is DONE.
REQ-012 blink  output  1  LED drive: 0 outside DONE, toggles on each tick inside DONE.

Function
REQ-013 Each button shall be converted to a press pulse: high for one cycle when the sampled level is 1 and the previous-cycle level was 0.
REQ-014 A held button shall produce exactly one press pulse, on the cycle it is first seen high.
REQ-015 The FSM shall have three states: COUNT, PAUSE, DONE.
REQ-016 COUNT + pause press -> PAUSE; PAUSE + pause press -> COUNT; a pause press in DONE is ignored.
REQ-017 A clear press in any state shall reload START_TENS/START_ONES, force blink=0, and enter PAUSE on the next cycle.
REQ-018 Clear shall take priority over pause and over tick in the same cycle.
REQ-019 In COUNT, a tick shall decrement the 2-digit BCD value by one on that clock edge.
REQ-020 Decrement shall follow BCD rules: ones>0 -> ones-1; ones==0 -> ones=9 and tens-1.
REQ-021 A tick in COUNT that takes the value from 01 to 00 shall enter DONE on the same edge.
REQ-022 The value shall never wrap below 00; ticks in PAUSE and DONE leave the digits unchanged.
REQ-023 COUNT with tick and pause press in the same cycle: the decrement is applied AND the state becomes PAUSE.
REQ-024 COUNT with value 01, tick and pause press in the same cycle: the value becomes 00 and the state becomes DONE; the pause press is discarded.
REQ-025 A pause press in PAUSE with value 00 (START=00) shall enter DONE, not COUNT.
REQ-026 All outputs shall be registered; counting and done shall be decoded from the state register with no combinational path from any input.
REQ-027 Latency: a press or tick at edge N is visible on the outputs after edge N.

Reset
REQ-028 While rst=0: state=COUNT, bcd_tens=START_TENS, bcd_ones=START_ONES, done=0, blink=0, counting=1, edge-detect history=0.
REQ-029 A reset assertion mid-operation shall abandon any count or pause immediately and asynchronously, with no partial decrement.
REQ-030 After reset release, the first tick shall decrement, because power-on starts counting.

Structure
REQ-031 A shared package shall hold the state encoding (COUNT, PAUSE, DONE; 2 bits) and the BCD constants 4'd9 and 4'd0.
REQ-032 One sub-module, btn_edge (level in, one-cycle press pulse out, same clk/rst), shall be instantiated once per button.
REQ-033 The BCD decrement shall stay inline in timer_ctrl; no further sub-modules.

Verification
REQ-034 Reset, then 3 ticks -> digits 30->29->28->27, counting=1, done=0.
REQ-035 At 25, hold btn_pause for 10 cycles, then 2 ticks -> state PAUSE, digits stay 25; release and press again -> COUNT, next tick gives 24.
REQ-036 From 10, one tick -> 09, showing the ones borrow; from 01, one tick -> 00, done=1, counting=0; 3 further ticks -> digits stay 00 and blink goes 1,0,1.
REQ-037 In DONE, press btn_clear -> next cycle digits 30, state PAUSE, done=0, blink=0; press btn_pause -> COUNT.
REQ-038 At 15 in COUNT, tick, pause press and clear press in the same cycle -> digits 30, state PAUSE (clear wins); repeat without clear -> digits 14, state PAUSE.
REQ-039 Assert rst mid-count at 12 between clock edges -> outputs return to 30/COUNT immediately, before the next clk edge.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the countdown timer.
// State encoding and BCD digit limits.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_COUNT = 2'd0,
    ST_PAUSE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level.
// Emits a single-cycle press pulse when the level first goes high.
module btn_edge
  import timer_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic lvl_i,
  output logic pulse_o
);

  logic prev_q;

  // Remember last cycle's level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= lvl_i;
  end

  assign pulse_o = lvl_i & ~prev_q;

endmodule

// File: rtl/timer_ctrl.sv
// Two-digit BCD countdown timer with pause/clear buttons.
// Counting/done decode straight from the state register.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter logic [3:0] START_TENS = 4'd3,
  parameter logic [3:0] START_ONES = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_pause,
  input  logic       btn_clear,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       counting,
  output logic       done,
  output logic       blink
);

  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       blink_q, blink_d;
  logic       pause_p, clear_p;
  logic       is_zero, is_one;

  btn_edge u_pause (
    .clk     (clk),
    .rst     (rst),
    .lvl_i   (btn_pause),
    .pulse_o (pause_p)
  );

  btn_edge u_clear (
    .clk     (clk),
    .rst     (rst),
    .lvl_i   (btn_clear),
    .pulse_o (clear_p)
  );

  assign is_zero = (tens_q == BCD_ZERO) && (ones_q == BCD_ZERO);
  assign is_one  = (tens_q == BCD_ZERO) && (ones_q == 4'd1);

  // Next state, BCD decrement and blink; clear overrides everything.
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    blink_d = blink_q;
    if (clear_p) begin
      state_d = ST_PAUSE;
      tens_d  = START_TENS;
      ones_d  = START_ONES;
      blink_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_COUNT: begin
          if (tick) begin
            if (is_zero) begin
              state_d = ST_DONE;
              blink_d = 1'b0;
            end else begin
              if (ones_q == BCD_ZERO) begin
                ones_d = BCD_NINE;
                tens_d = tens_q - 4'd1;
              end else begin
                ones_d = ones_q - 4'd1;
              end
              if (is_one) begin
                state_d = ST_DONE;
                blink_d = 1'b0;
              end else if (pause_p) begin
                state_d = ST_PAUSE;
              end
            end
          end else if (pause_p) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pause_p) begin
            state_d = is_zero ? ST_DONE : ST_COUNT;
          end
        end
        ST_DONE: begin
          if (tick) blink_d = ~blink_q;
        end
        default: begin
          state_d = ST_COUNT;
          blink_d = 1'b0;
        end
      endcase
    end
  end

  // State, digit and blink registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_COUNT;
      tens_q  <= START_TENS;
      ones_q  <= START_ONES;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      blink_q <= blink_d;
    end
  end

  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
  assign blink    = blink_q;
  assign counting = (state_q == ST_COUNT);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl.
// Vector table, corner sequences, random run vs integer model.
module tb_timer_ctrl;

  localparam int START = 30;
  localparam int M_RUN = 0;
  localparam int M_HOLD = 1;
  localparam int M_END = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic bp = 1'b0;
  logic bc = 1'b0;
  logic [3:0] tens, ones;
  logic cnt, dn, blk;

  logic z_tick = 1'b0;
  logic z_bp = 1'b0;
  logic z_bc = 1'b0;
  logic [3:0] z_tens, z_ones;
  logic z_cnt, z_dn, z_blk;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  timer_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn_pause (bp),
    .btn_clear (bc),
    .bcd_tens  (tens),
    .bcd_ones  (ones),
    .counting  (cnt),
    .done      (dn),
    .blink     (blk)
  );

  timer_ctrl #(.START_TENS(4'd0), .START_ONES(4'd0)) dut_z (
    .clk       (clk),
    .rst       (rst),
    .tick      (z_tick),
    .btn_pause (z_bp),
    .btn_clear (z_bc),
    .bcd_tens  (z_tens),
    .bcd_ones  (z_ones),
    .counting  (z_cnt),
    .done      (z_dn),
    .blink     (z_blk)
  );

  typedef struct {
    logic t;
    logic p;
    logic c;
    int   val;
    logic e_cnt;
    logic e_dn;
    logic e_blk;
  } vec_t;

  vec_t vecs[$];

  // reference model: value as an integer 0..99
  int   m_val;
  int   m_st;
  logic m_blk;
  logic m_pp, m_pc;

  function automatic logic [10:0] pack_exp(int v, logic c, logic d, logic b);
    logic [3:0] t4, o4;
    t4 = 4'(v / 10);
    o4 = 4'(v % 10);
    return {t4, o4, c, d, b};
  endfunction

  task automatic add(input logic t, p, c, input int v,
                     input logic ec, ed, eb);
    vec_t e;
    e.t = t; e.p = p; e.c = c; e.val = v;
    e.e_cnt = ec; e.e_dn = ed; e.e_blk = eb;
    vecs.push_back(e);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [10:0] act, input logic [10:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got t=%0d o=%0d cnt=%b dn=%b blk=%b, want t=%0d o=%0d cnt=%b dn=%b blk=%b",
               nm, idx, act[10:7], act[6:3], act[2], act[1], act[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [10:0] dut_out();
    return {tens, ones, cnt, dn, blk};
  endfunction

  function automatic logic [10:0] z_out();
    return {z_tens, z_ones, z_cnt, z_dn, z_blk};
  endfunction

  task automatic model_reset();
    m_val = START; m_st = M_RUN; m_blk = 1'b0;
    m_pp = 1'b0; m_pc = 1'b0;
  endtask

  task automatic model_edge(input logic t, p, c);
    logic pp, pc;
    pp = p & ~m_pp;
    pc = c & ~m_pc;
    m_pp = p;
    m_pc = c;
    if (pc) begin
      m_val = START; m_st = M_HOLD; m_blk = 1'b0;
    end else if (m_st == M_RUN) begin
      if (t) begin
        if (m_val > 0) m_val = m_val - 1;
        if (m_val == 0) begin
          m_st = M_END; m_blk = 1'b0;
        end else if (pp) m_st = M_HOLD;
      end else if (pp) m_st = M_HOLD;
    end else if (m_st == M_HOLD) begin
      if (pp) m_st = (m_val == 0) ? M_END : M_RUN;
    end else begin
      if (t) m_blk = ~m_blk;
    end
  endtask

  task automatic chk_model(input string nm, input int idx);
    chk(nm, idx, dut_out(),
        pack_exp(m_val, m_st == M_RUN, m_st == M_END, m_blk));
  endtask

  task automatic apply(input logic t, p, c, input string nm, input int idx);
    @(negedge clk);
    tick = t; bp = p; bc = c;
    @(posedge clk);
    model_edge(t, p, c);
    #1;
    chk_model(nm, idx);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 0; bp = 0; bc = 0;
    z_tick = 0; z_bp = 0; z_bc = 0;
    rst = 1'b0;
    #1;
    model_reset();
    chk_model("reset", 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // power-on reset
    @(posedge clk);
    #1;
    model_reset();
    chk_model("por", 0);
    @(negedge clk);
    rst = 1'b1;

    // vector table
    for (int v = 29; v >= 25; v--) add(1, 0, 0, v, 1, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 25, 0, 0, 0);
    add(1, 0, 0, 25, 0, 0, 0);
    add(1, 0, 0, 25, 0, 0, 0);
    add(0, 1, 0, 25, 1, 0, 0);
    add(1, 0, 0, 24, 1, 0, 0);
    for (int v = 23; v >= 1; v--) add(1, 0, 0, v, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 1, 30, 0, 0, 0);
    add(0, 0, 0, 30, 0, 0, 0);
    add(0, 1, 0, 30, 1, 0, 0);
    add(0, 0, 0, 30, 1, 0, 0);
    for (int v = 29; v >= 15; v--) add(1, 0, 0, v, 1, 0, 0);
    add(1, 1, 1, 30, 0, 0, 0);
    add(0, 0, 0, 30, 0, 0, 0);
    add(0, 1, 0, 30, 1, 0, 0);
    add(0, 0, 0, 30, 1, 0, 0);
    for (int v = 29; v >= 15; v--) add(1, 0, 0, v, 1, 0, 0);
    add(1, 1, 0, 14, 0, 0, 0);
    add(0, 0, 0, 14, 0, 0, 0);
    add(0, 1, 0, 14, 1, 0, 0);
    add(0, 0, 0, 14, 1, 0, 0);
    for (int v = 13; v >= 1; v--) add(1, 0, 0, v, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 30, 0, 0, 0);
    add(1, 0, 1, 30, 0, 0, 0);
    add(1, 1, 1, 30, 1, 0, 0);
    add(0, 0, 0, 30, 1, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      tick = vecs[i].t; bp = vecs[i].p; bc = vecs[i].c;
      @(posedge clk);
      #1;
      chk("vec", i, dut_out(),
          pack_exp(vecs[i].val, vecs[i].e_cnt, vecs[i].e_dn, vecs[i].e_blk));
    end

    // async reset mid-count at 12, then first tick decrements
    do_reset();
    for (int i = 0; i < 18; i++) apply(1, 0, 0, "to12", i);
    chk("at12", 0, dut_out(), pack_exp(12, 1, 0, 0));
    @(negedge clk);
    tick = 0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst", 0, dut_out(), pack_exp(30, 1, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    apply(1, 0, 0, "first_tick", 0);
    chk("first_tick29", 0, dut_out(), pack_exp(29, 1, 0, 0));

    // START=00: pause from PAUSE goes to DONE; tick never wraps
    do_reset();
    @(negedge clk); z_bp = 1;
    @(posedge clk); #1;
    chk("z_pause", 0, z_out(), pack_exp(0, 0, 0, 0));
    @(negedge clk); z_bp = 0;
    @(negedge clk); z_bp = 1;
    @(posedge clk); #1;
    chk("z_done", 0, z_out(), pack_exp(0, 0, 1, 0));
    do_reset();
    @(negedge clk); z_tick = 1;
    @(posedge clk); #1;
    chk("z_nowrap", 0, z_out(), pack_exp(0, 0, 1, 0));
    @(negedge clk); z_tick = 0;

    // random run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic t, p, c;
      @(negedge clk);
      t = ($urandom % 3) == 0;
      p = (($urandom % 8) == 0) ? ~bp : bp;
      c = bc ? (($urandom % 3) != 0) : (($urandom % 400) == 0);
      tick = t; bp = p; bc = c;
      if (($urandom % 250) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_model("rnd_rst", i);
        #1;
        rst = 1'b1;
      end
      @(posedge clk);
      model_edge(t, p, c);
      #1;
      chk_model("rnd", i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
